// File: rtl/fetch_queue.sv
// Instruction fetch queue: strict FIFO of PC/instruction pairs between fetch and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards an offered entry straight to decode when the queue is empty.
module fetch_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic [ADDR_WIDTH-1:0]          in_pc,
    input  logic [INSTR_WIDTH-1:0]         in_instr,
    output logic                           in_ready,
    input  logic                           flush,
    output logic                           out_valid,
    output logic [ADDR_WIDTH-1:0]          out_pc,
    output logic [INSTR_WIDTH-1:0]         out_instr,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   live_q;
    logic [ADDR_WIDTH-1:0]  pcMem_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instrMem_q [DEPTH];

    logic headValid;
    logic bypass;
    logic push;
    logic pop;
    logic writeEn;
    logic readEn;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

    // live_q keeps in_ready low until the first clock edge after reset releases
    assign in_ready  = live_q && !full && !flush;
    assign headValid = !empty && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = live_q && empty && in_valid && !flush;

    always_comb begin
        out_valid = headValid || bypass;
        out_pc    = '0;
        out_instr = '0;
        if (headValid) begin
            out_pc    = pcMem_q[rdPtr_q];
            out_instr = instrMem_q[rdPtr_q];
        end else if (bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end
`else
    assign bypass = 1'b0;

    always_comb begin
        out_valid = headValid;
        out_pc    = '0;
        out_instr = '0;
        if (headValid) begin
            out_pc    = pcMem_q[rdPtr_q];
            out_instr = instrMem_q[rdPtr_q];
        end
    end
`endif

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    // A bypassed entry consumed in the same cycle never touches storage
    assign writeEn = push && !(bypass && out_ready);
    assign readEn  = pop && headValid;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (writeEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (readEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({writeEn, readEn})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            live_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            live_q  <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q and the pointers
    always_ff @(posedge clk) begin
        if (writeEn) begin
            pcMem_q[wrPtr_q]    <= in_pc;
            instrMem_q[wrPtr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard testbench for fetch_queue: stimulus queues expected heads, a negedge monitor checks every pop.
module tb_fetch_queue;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic [AW-1:0] in_pc;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    logic [63:0] expQ [$];
    logic [63:0] monExp;
    int checkCount = 0;
    int failCount  = 0;

    fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ordy,
                                 input logic fl, input logic expPush);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instrOf(pc);
        out_ready = ordy;
        flush     = fl;
        if (expPush) expQ.push_back({pc, instrOf(pc)});
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fillEntries(input logic [31:0] basePc, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, basePc + 32'(4 * i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (n) tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every accepted head must match the oldest expected entry; idle heads must read zero
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL unexpected_pop actual_pc=0x%0h expected=none", out_pc);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("head_pc", 64'(out_pc), 64'(monExp[63:32]));
                checkOutput("head_instr", 64'(out_instr), 64'(monExp[31:0]));
            end
        end else if (out_valid === 1'b0) begin
            checkOutput("idle_zero", {out_pc, out_instr}, 64'h0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_empty", 64'(empty), 64'd1);
        checkOutput("rst_full", 64'(full), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Fill to full, then drain in order
        fillEntries(32'h0, 4);
        checkOutput("fill_full", 64'(full), 64'd1);
        checkOutput("fill_count", 64'(count), 64'd4);
        checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
        drain(4);
        checkOutput("drain_empty", 64'(empty), 64'd1);
        checkOutput("drain_count", 64'(count), 64'd0);

        // Pop from full with in_valid held: ready only in the following cycle
        fillEntries(32'h20, 4);
        applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
        checkOutput("full_pop_in_ready", 64'(in_ready), 64'd0);
        tick();
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
        checkOutput("after_pop_in_ready", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("refill_count", 64'(count), 64'd4);
        checkOutput("refill_full", 64'(full), 64'd1);
        drain(4);

        // Steady push+pop at DEPTH-1 across pointer wrap
        fillEntries(32'h50, 3);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h5C + 32'(4 * i), 1'b1, 1'b0, 1'b1);
            tick();
            checkOutput("steady_count", 64'(count), 64'd3);
        end
        drain(3);
        checkOutput("steady_drain_empty", 64'(empty), 64'd1);

        // Single-cycle flush with an offered entry that must vanish
        fillEntries(32'h60, 3);
        expQ.delete();
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_flush_count", 64'(count), 64'd0);
        checkOutput("post_flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("post_flush_empty", 64'(empty), 64'd1);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_flush_head_valid", 64'(out_valid), 64'd1);
        checkOutput("post_flush_head_pc", 64'(out_pc), 64'h200);
        drain(1);

        // Flush held for several cycles
        fillEntries(32'h80, 2);
        expQ.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h90, 1'b1, 1'b1, 1'b0);
            checkOutput("flush_hold_in_ready", 64'(in_ready), 64'd0);
            tick();
            checkOutput("flush_hold_empty", 64'(empty), 64'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges discards queued entries
        fillEntries(32'h70, 2);
        #2;
        reset_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_count", 64'(count), 64'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rerst_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        tick();
        drain(1);

        // Empty-queue push with decode ready
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput("bypass_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bypass_out_pc", 64'(out_pc), 64'h40);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("bypass_count", 64'(count), 64'd0);
`else
        checkOutput("nobypass_out_valid", 64'(out_valid), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("nobypass_count", 64'(count), 64'd1);
        checkOutput("nobypass_out_valid_next", 64'(out_valid), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("nobypass_count_after", 64'(count), 64'd0);
`endif

        tick();
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: PC width.
REQ-002 Parameter INSTR_WIDTH, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: entry count; power of two, >=2.
REQ-004 The ports SHALL be:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: fetch stage presents a PC/instruction pair.
- in_pc, input, ADDR_WIDTH: PC of the offered instruction.
- in_instr, input, INSTR_WIDTH: offered instruction word.
- in_ready, output, 1: queue accepts an entry this cycle.
- flush, input, 1: branch taken; discard all queued entries.
- out_valid, output, 1: head entry is available to decode.
- out_pc, output, ADDR_WIDTH: head PC.
- out_instr, output, INSTR_WIDTH: head instruction.
- out_ready, input, 1: decode consumes the head this cycle.
- count, output, $clog2(DEPTH+1): number of occupied entries.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.

Function
REQ-005 Push: occurs when in_valid && in_ready; the entry is written at the write pointer, which then advances.
REQ-006 Pop: occurs when out_valid && out_ready; the read pointer advances.
REQ-007 Ordering: the queue SHALL be strict FIFO order and SHALL NOT drop or duplicate entries.
REQ-008 Backpressure: in_ready = !full && !flush. It is combinational from state and flush only, never from out_ready.
REQ-009 out_valid = !empty && !flush, unless bypass is enabled (REQ-021).
REQ-010 Head data: out_pc and out_instr show the head entry. Both SHALL be all zeros whenever out_valid = 0.
REQ-011 Pointers: read and write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no bubble.
REQ-012 Count update per cycle: push only gives +1; pop only gives -1; simultaneous push and pop leaves count unchanged; neither leaves it unchanged.
REQ-013 Simultaneous push and pop with count == DEPTH-1: the queue SHALL reach neither full nor empty; count stays DEPTH-1.
REQ-014 Full: no push is possible. A pop in the full cycle makes in_ready = 1 in the following cycle.
REQ-015 Empty: out_valid = 0, and out_ready is ignored.
REQ-016 Flush: in the flush cycle, no push and no pop occur. In the next cycle count = 0, pointers = 0, and empty = 1. A push is accepted from the cycle after flush deasserts.
REQ-017 Flush held for multiple cycles: the queue SHALL stay empty and in_ready SHALL stay 0 throughout.
REQ-018 Latency without bypass: an entry pushed in cycle N is visible on out_valid in cycle N+1.

Reset
REQ-019 Reset takes effect on reset_n low, asynchronously. It sets pointers = 0, count = 0, empty = 1, full = 0, out_valid = 0, out_pc = 0, out_instr = 0, in_ready = 0.
REQ-020 Exit from reset: in_ready = 1 from the first clock edge with reset_n high. Reset asserted mid-operation SHALL discard all entries; no entry pushed before reset may appear afterwards.

Configuration
REQ-021 Macro FETCH_QUEUE_BYPASS_EN, when defined: if empty && in_valid && !flush, then out_valid = 1 and out_pc/out_instr = in_pc/in_instr combinationally.
- If out_ready is also 1, the entry is consumed and not written, and count stays 0.
- If out_ready is 0, the entry is written as a normal push.
REQ-022 Macro FETCH_QUEUE_BYPASS_EN, when undefined: no combinational in-to-out path exists, and latency is exactly one cycle per REQ-018.

Verification
REQ-023 Reset, then push PCs 0x0, 0x4, 0x8, 0xC with out_ready = 0 -> full = 1, count = 4, in_ready = 0. Then pop 4 -> out_pc sequence 0x0, 0x4, 0x8, 0xC, and empty = 1.
REQ-024 Fill to 3 entries, then hold push and pop together for 8 cycles with PCs incrementing by 4 -> count stays 3, pointers wrap, and output order is preserved.
REQ-025 Hold 3 entries, then assert flush for 1 cycle with in_valid = 1 and in_pc = 0x100 -> next cycle count = 0 and out_valid = 0; 0x100 never appears. Next push of 0x200 appears as the head.
REQ-026 Hold 2 entries, then pulse reset_n low asynchronously between clock edges -> out_valid drops immediately and count = 0; after release the first output is the next pushed PC.
REQ-027 Empty queue, push 0x40 with out_ready = 1 -> with FETCH_QUEUE_BYPASS_EN, out_valid = 1 and out_pc = 0x40 in the same cycle with count staying 0; without the macro, out_valid = 1 one cycle later with count = 1 before the pop.
REQ-028 Full queue, pop 1 with in_valid held -> in_ready = 0 in the pop cycle and 1 in the next cycle; the next push is accepted and count returns to 4.
